// File: rtl/async_fifo_wr_ctrl_pkg.sv
// Shared definitions for the async FIFO pointer controllers (write and read side).
// Holds the default geometry and the binary-to-gray helper.
package async_fifo_wr_ctrl_pkg;

    localparam int ADDR_W_DEF    = 4;
    localparam int PTR_W_DEF     = ADDR_W_DEF + 1;
    localparam int AF_THRESH_DEF = 12;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_gray2bin.sv
// Gray-to-binary converter: bit i is the XOR of every gray bit at or above i.
// Purely combinational and shared with the read-side controller.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer / full-flag controller for the async UART FIFO.
// Drives the RAM write port and publishes a registered gray write pointer.
module async_fifo_wr_ctrl
    import async_fifo_wr_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_req,
    input  logic [ADDR_W:0]   i_rd_ptr_gray_s,
    input  logic              i_ovf_clr,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [ADDR_W:0]   o_wr_ptr_gray,
    output logic              o_full,
    output logic              o_almost_full,
    output logic [ADDR_W:0]   o_level,
    output logic              o_overflow
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr_bin;
    logic [PTR_W-1:0] r_wr_ptr_gray;
    logic [PTR_W-1:0] r_level;
    logic             r_full;
    logic             r_almost_full;
    logic             r_overflow;

    logic             w_accept;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_next;
    logic [PTR_W-1:0] w_full_cmp;
    logic [PTR_W-1:0] w_rd_bin;
    logic [PTR_W-1:0] w_level_next;
    logic             w_full_next;
    logic             w_af_next;

    gray2bin #(.WIDTH(PTR_W)) u_rd_g2b (
        .i_gray (i_rd_ptr_gray_s),
        .o_bin  (w_rd_bin)
    );

    // Reset suppresses the RAM strobe so nothing lands in memory during reset.
    assign w_accept    = i_wr_req & ~r_full & ~i_reset;
    assign w_bin_next  = r_wr_ptr_bin + PTR_W'(w_accept);
    assign w_gray_next = PTR_W'(bin2gray(32'(w_bin_next)));

    // Full when the next write pointer is one lap ahead of the read pointer:
    // in gray code that means the top two bits inverted, the rest equal.
    assign w_full_cmp   = {~i_rd_ptr_gray_s[PTR_W-1:PTR_W-2], i_rd_ptr_gray_s[PTR_W-3:0]};
    assign w_full_next  = (w_gray_next == w_full_cmp);
    assign w_level_next = w_bin_next - w_rd_bin;
    assign w_af_next    = (32'(w_level_next) >= 32'(AF_THRESH));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr_bin  <= '0;
            r_wr_ptr_gray <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_wr_ptr_bin  <= w_bin_next;
            r_wr_ptr_gray <= w_gray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_af_next;
            r_level       <= w_level_next;
            // A rejected write outranks a clear arriving in the same cycle.
            if (i_wr_req & r_full)
                r_overflow <= 1'b1;
            else if (i_ovf_clr)
                r_overflow <= 1'b0;
        end
    end

    assign o_mem_we      = w_accept;
    assign o_mem_waddr   = r_wr_ptr_bin[ADDR_W-1:0];
    assign o_wr_ptr_gray = r_wr_ptr_gray;
    assign o_full        = r_full;
    assign o_almost_full = r_almost_full;
    assign o_level       = r_level;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for the async FIFO write controller (ADDR_W=4, AF_THRESH=12).
module tb_async_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       reset, wr_req, ovf_clr;
    logic [4:0] rd_ptr_gray_s;
    logic       mem_we, full, almost_full, overflow;
    logic [3:0] mem_waddr;
    logic [4:0] wr_ptr_gray, level;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    async_fifo_wr_ctrl #(.ADDR_W(4), .AF_THRESH(12)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_wr_req        (wr_req),
        .i_rd_ptr_gray_s (rd_ptr_gray_s),
        .i_ovf_clr       (ovf_clr),
        .o_mem_we        (mem_we),
        .o_mem_waddr     (mem_waddr),
        .o_wr_ptr_gray   (wr_ptr_gray),
        .o_full          (full),
        .o_almost_full   (almost_full),
        .o_level         (level),
        .o_overflow      (overflow)
    );

    function automatic logic [4:0] g(input int b);
        logic [4:0] bb;
        bb = 5'(b);
        return bb ^ (bb >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_req = 1'b0; ovf_clr = 1'b0; rd_ptr_gray_s = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            wr_req = 1'b1;
            #1;
            chk($sformatf("fill_we%0d", i), 32'(mem_we), 1);
            chk($sformatf("fill_addr%0d", i), 32'(mem_waddr), i);
            tick();
            chk($sformatf("fill_lvl%0d", i), 32'(level), i + 1);
            chk($sformatf("fill_full%0d", i), 32'(full), (i == 15) ? 1 : 0);
            chk($sformatf("fill_af%0d", i), 32'(almost_full), (i + 1 >= 12) ? 1 : 0);
        end
        wr_req = 1'b0;
    endtask

    logic [4:0] prev_g;
    int         rd_b;

    initial begin
        reset = 1'b1; wr_req = 1'b0; ovf_clr = 1'b0; rd_ptr_gray_s = '0;
        #2;
        // Test 1: reset state, then fill
        do_reset();
        chk("rst_gray", 32'(wr_ptr_gray), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_lvl", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_addr", 32'(mem_waddr), 0);
        fill16();
        chk("full_gray", 32'(wr_ptr_gray), 32'h18);

        // Test 2: writes while full
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1;
            #1;
            chk($sformatf("ovf_we%0d", i), 32'(mem_we), 0);
            tick();
            chk($sformatf("ovf_gray%0d", i), 32'(wr_ptr_gray), 32'h18);
            chk($sformatf("ovf_set%0d", i), 32'(overflow), 1);
        end
        wr_req = 1'b0; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // Test 3: reader frees 4 slots
        rd_ptr_gray_s = 5'b00110;
        tick();
        chk("free_full", 32'(full), 0);
        chk("free_lvl", 32'(level), 12);
        chk("free_af", 32'(almost_full), 1);
        wr_req = 1'b1;
        #1;
        chk("free_we", 32'(mem_we), 1);
        chk("free_addr", 32'(mem_waddr), 0);
        tick();
        wr_req = 1'b0;
        chk("free_lvl2", 32'(level), 13);

        // Test 4: 40 writes, reader 2 cycles behind
        do_reset();
        prev_g = 5'd0;
        for (int k = 0; k < 40; k++) begin
            rd_b = (k >= 2) ? k - 2 : 0;
            rd_ptr_gray_s = g(rd_b);
            wr_req = 1'b1;
            #1;
            chk($sformatf("wrap_addr%0d", k), 32'(mem_waddr), k % 16);
            tick();
            chk($sformatf("wrap_gray%0d", k), 32'(wr_ptr_gray), 32'(g((k + 1) % 32)));
            chk($sformatf("wrap_1bit%0d", k), $countones(wr_ptr_gray ^ prev_g), 1);
            chk($sformatf("wrap_full%0d", k), 32'(full), 0);
            chk($sformatf("wrap_lvl%0d", k), 32'(level), (k + 1) - rd_b);
            prev_g = wr_ptr_gray;
        end
        wr_req = 1'b0;

        // Test 5: reset mid-fill with wr_req high
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wr_req = 1'b1;
            tick();
        end
        chk("mid_lvl", 32'(level), 7);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 32'(mem_we), 0);
        tick();
        chk("mid_gray", 32'(wr_ptr_gray), 0);
        chk("mid_lvl0", 32'(level), 0);
        chk("mid_full", 32'(full), 0);
        chk("mid_af", 32'(almost_full), 0);
        chk("mid_ovf", 32'(overflow), 0);
        chk("mid_addr", 32'(mem_waddr), 0);
        reset = 1'b0; wr_req = 1'b0;

        // Test 6: set beats clear
        do_reset();
        fill16();
        wr_req = 1'b1; ovf_clr = 1'b1;
        tick();
        wr_req = 1'b0; ovf_clr = 1'b0;
        chk("setwins_ovf", 32'(overflow), 1);
        chk("setwins_full", 32'(full), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
